// File: rtl/mips32_pkg.sv
// Shared mips32 datapath definitions: extension mode encodings and the
// width-legality check used by the extension units.
package mips32_pkg;

  typedef enum logic [1:0] {
    EXT_SIGN    = 2'b00,
    EXT_ZERO    = 2'b01,
    EXT_UPPER   = 2'b10,
    EXT_SUBWORD = 2'b11
  } ext_mode_e;

  // True when the output can hold the operand and the sub-word fits inside it.
  function automatic bit ext_widths_ok(input int in_w, input int out_w, input int sub_w);
    return (out_w >= in_w) && (sub_w >= 1) && (sub_w <= in_w);
  endfunction

endpackage

// File: rtl/ext_core.sv
// Purely combinational operand extender: sign, zero, upper placement (LUI)
// or sub-word sign extension (lb/lh). Shared with the load-alignment unit.
module ext_core
  import mips32_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SUB_W = 8
) (
  input  logic [IN_W-1:0]  data_i,
  input  logic [1:0]       mode_i,
  output logic [OUT_W-1:0] data_o
);

  logic signed [IN_W-1:0]  in_s;
  logic signed [SUB_W-1:0] sub_s;

  assign in_s  = signed'(data_i);
  assign sub_s = signed'(data_i[SUB_W-1:0]);

  // Select the extension; size casts of signed operands replicate the sign bit,
  // and with OUT_W == IN_W the casts and the zero-distance shift are identities.
  always_comb begin
    data_o = '0;
    case (mode_i)
      EXT_SIGN:    data_o = OUT_W'(in_s);
      EXT_ZERO:    data_o = OUT_W'(data_i);
      EXT_UPPER:   data_o = OUT_W'(data_i) << (OUT_W - IN_W);
      EXT_SUBWORD: data_o = OUT_W'(sub_s);
      default:     data_o = '0;
    endcase
  end

endmodule

// File: rtl/ext_unit_pipe.sv
// Registered operand extender behind a valid/ready handshake. A main register
// (M) drives the outputs and a skid register (S) absorbs the one extra operand
// that can arrive while M is stalled, so in_ready comes straight from a flop.
module ext_unit_pipe
  import mips32_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SUB_W = 8,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  if (!ext_widths_ok(IN_W, OUT_W, SUB_W)) begin : g_width_err
    $error("ext_unit_pipe: illegal widths IN_W=%0d OUT_W=%0d SUB_W=%0d", IN_W, OUT_W, SUB_W);
  end

  logic [OUT_W-1:0] ext_res;

  logic             m_vld_q,  m_vld_d;
  logic [OUT_W-1:0] m_data_q, m_data_d;
  logic [TAG_W-1:0] m_tag_q,  m_tag_d;
  logic             s_vld_q,  s_vld_d;
  logic [OUT_W-1:0] s_data_q, s_data_d;
  logic [TAG_W-1:0] s_tag_q,  s_tag_d;

  logic accept;
  logic deliver;

  ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SUB_W (SUB_W)
  ) u_ext_core (
    .data_i (in_data),
    .mode_i (in_mode),
    .data_o (ext_res)
  );

  assign in_ready  = ~s_vld_q;
  assign out_valid = m_vld_q;
  assign out_data  = m_data_q;
  assign out_tag   = m_tag_q;

  assign accept  = in_valid & ~s_vld_q;
  assign deliver = m_vld_q & out_ready;

  // Next-state for M/S in priority order: flush, drain S into M, refill M, spill into S.
  always_comb begin
    m_vld_d  = m_vld_q;
    m_data_d = m_data_q;
    m_tag_d  = m_tag_q;
    s_vld_d  = s_vld_q;
    s_data_d = s_data_q;
    s_tag_d  = s_tag_q;
    if (flush) begin
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (deliver && s_vld_q) begin
      // in_ready is low here, so no new operand competes with the transfer.
      m_vld_d  = 1'b1;
      m_data_d = s_data_q;
      m_tag_d  = s_tag_q;
      s_vld_d  = 1'b0;
    end else if (deliver || !m_vld_q) begin
      m_vld_d = accept;
      if (accept) begin
        m_data_d = ext_res;
        m_tag_d  = in_tag;
      end
    end else if (accept) begin
      s_vld_d  = 1'b1;
      s_data_d = ext_res;
      s_tag_d  = in_tag;
    end
  end

  // State registers; reset clears every held entry immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_vld_q  <= 1'b0;
      m_data_q <= '0;
      m_tag_q  <= '0;
      s_vld_q  <= 1'b0;
      s_data_q <= '0;
      s_tag_q  <= '0;
    end else begin
      m_vld_q  <= m_vld_d;
      m_data_q <= m_data_d;
      m_tag_q  <= m_tag_d;
      s_vld_q  <= s_vld_d;
      s_data_q <= s_data_d;
      s_tag_q  <= s_tag_d;
    end
  end

endmodule

// File: tb/tb_ext_unit_pipe.sv
// Bench for ext_unit_pipe: default-width instance driven by directed and random
// traffic against a 2-deep FIFO reference, plus a narrow (8->16) instance.
module tb_ext_unit_pipe;
  import mips32_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // Default-width instance
  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_data;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag, out_tag;
  logic [31:0] out_data;

  // Narrow instance
  logic        p_flush, p_in_valid, p_in_ready, p_out_valid, p_out_ready;
  logic [7:0]  p_in_data;
  logic [1:0]  p_in_mode;
  logic [2:0]  p_in_tag, p_out_tag;
  logic [15:0] p_out_data;

  ext_unit_pipe #(.IN_W(16), .OUT_W(32), .SUB_W(8), .TAG_W(5)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  ext_unit_pipe #(.IN_W(8), .OUT_W(16), .SUB_W(4), .TAG_W(3)) dut8 (
    .clock(clock), .reset(reset), .flush(p_flush),
    .in_valid(p_in_valid), .in_ready(p_in_ready), .in_data(p_in_data),
    .in_mode(p_in_mode), .in_tag(p_in_tag),
    .out_valid(p_out_valid), .out_ready(p_out_ready),
    .out_data(p_out_data), .out_tag(p_out_tag)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  t;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Extension by arithmetic on integer values, reduced modulo 2^ow.
  function automatic logic [31:0] ref_ext(input int unsigned d, input int m,
                                          input int iw, input int ow, input int sw);
    longint v, w_in, w_out, w_sub;
    w_in  = longint'(1) << iw;
    w_out = longint'(1) << ow;
    w_sub = longint'(1) << sw;
    case (m)
      0: begin
        v = longint'(d) % w_in;
        if (v >= w_in / 2) v = v - w_in;
      end
      1: v = longint'(d) % w_in;
      2: v = (longint'(d) % w_in) * (longint'(1) << (ow - iw));
      default: begin
        v = longint'(d) % w_sub;
        if (v >= w_sub / 2) v = v - w_sub;
      end
    endcase
    v = v % w_out;
    if (v < 0) v = v + w_out;
    return 32'(v);
  endfunction

  // One cycle on the default instance: check outputs against the model, apply
  // inputs, advance the model by what the edge should do, then cross the edge.
  task automatic step(input logic v, input logic [15:0] d, input logic [1:0] m,
                      input logic [4:0] t, input logic ordy, input logic fl);
    bit acc, dlv;
    in_valid  = v;
    in_data   = d;
    in_mode   = m;
    in_tag    = t;
    out_ready = ordy;
    flush     = fl;
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_data", 64'(out_data), 64'(q[0].d));
      chk("out_tag", 64'(out_tag), 64'(q[0].t));
    end
    acc = v && (q.size() < 2);
    dlv = (q.size() > 0) && ordy;
    if (fl) begin
      q.delete();
    end else begin
      if (dlv) void'(q.pop_front());
      if (acc) q.push_back('{d: ref_ext(int'(d), int'(m), 16, 32, 8), t: t});
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    flush = 0; in_valid = 0; in_data = '0; in_mode = '0; in_tag = '0; out_ready = 0;
    p_flush = 0; p_in_valid = 0; p_in_data = '0; p_in_mode = '0; p_in_tag = '0; p_out_ready = 0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_tag", 64'(out_tag), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst8_out_valid", 64'(p_out_valid), 64'(0));
    chk("rst8_in_ready", 64'(p_in_ready), 64'(1));
    reset = 1'b0;

    // Single SIGN operand
    step(1, 16'h8001, EXT_SIGN, 5'd3, 1, 0);
    chk("sign_first", 64'(out_data), 64'(32'hFFFF8001));
    step(0, '0, EXT_SIGN, '0, 1, 0);

    // Back-to-back stream in all four modes
    step(1, 16'h7FFF, EXT_SIGN,    5'd1, 1, 0);
    step(1, 16'h8001, EXT_ZERO,    5'd2, 1, 0);
    step(1, 16'h1234, EXT_UPPER,   5'd4, 1, 0);
    step(1, 16'h0080, EXT_SUBWORD, 5'd5, 1, 0);
    chk("subword_last", 64'(out_data), 64'(32'hFFFFFF80));
    step(0, '0, EXT_SIGN, '0, 1, 0);
    step(0, '0, EXT_SIGN, '0, 1, 0);

    // Backpressure: third operand waits until S drains
    step(1, 16'h0011, EXT_ZERO, 5'd6, 0, 0);
    step(1, 16'h0022, EXT_ZERO, 5'd7, 0, 0);
    step(1, 16'h0033, EXT_ZERO, 5'd8, 0, 0);
    chk("full_in_ready", 64'(in_ready), 64'(0));
    step(1, 16'h0033, EXT_ZERO, 5'd8, 0, 0);
    step(1, 16'h0033, EXT_ZERO, 5'd8, 1, 0);
    step(1, 16'h0033, EXT_ZERO, 5'd8, 1, 0);
    step(0, '0, EXT_SIGN, '0, 1, 0);
    step(0, '0, EXT_SIGN, '0, 1, 0);

    // Flush with M and S full and a simultaneous operand
    step(1, 16'hAAAA, EXT_SIGN, 5'd9,  0, 0);
    step(1, 16'hBBBB, EXT_SIGN, 5'd10, 0, 0);
    step(1, 16'hCCCC, EXT_SIGN, 5'd11, 0, 1);
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    chk("flush_in_ready", 64'(in_ready), 64'(1));
    step(0, '0, EXT_SIGN, '0, 1, 0);
    step(1, 16'h0001, EXT_UPPER, 5'd12, 1, 0);
    step(0, '0, EXT_SIGN, '0, 1, 0);

    // Asynchronous reset between edges with entries held
    step(1, 16'h5555, EXT_ZERO, 5'd13, 0, 0);
    step(1, 16'h6666, EXT_ZERO, 5'd14, 0, 0);
    in_valid = 0;
    #3 reset = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_out_data", 64'(out_data), 64'(0));
    chk("arst_out_tag", 64'(out_tag), 64'(0));
    chk("arst_in_ready", 64'(in_ready), 64'(1));
    q.delete();
    #1 reset = 1'b0;
    step(1, 16'hFFFF, EXT_SIGN, 5'd15, 1, 0);
    chk("post_rst_sign", 64'(out_data), 64'(32'hFFFFFFFF));
    step(0, '0, EXT_SIGN, '0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom), 5'($urandom),
           1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 39) == 0));
    end
    for (int i = 0; i < 3; i++) step(0, '0, EXT_SIGN, '0, 1, 0);

    // Narrow instance: 8 -> 16 with 4-bit sub-word
    begin
      logic [7:0] pd[4];
      logic [1:0] pm[4];
      pd[0] = 8'h08; pm[0] = EXT_SUBWORD;
      pd[1] = 8'hAB; pm[1] = EXT_UPPER;
      pd[2] = 8'h80; pm[2] = EXT_SIGN;
      pd[3] = 8'h80; pm[3] = EXT_ZERO;
      p_out_ready = 1;
      for (int i = 0; i < 4; i++) begin
        p_in_valid = 1;
        p_in_data  = pd[i];
        p_in_mode  = pm[i];
        p_in_tag   = 3'(i + 1);
        @(posedge clock);
        #1;
        p_in_valid = 0;
        chk("p8_valid", 64'(p_out_valid), 64'(1));
        chk("p8_data", 64'(p_out_data), 64'(ref_ext(int'(pd[i]), int'(pm[i]), 8, 16, 4)));
        chk("p8_tag", 64'(p_out_tag), 64'(i + 1));
      end
      @(posedge clock);
      #1;
      chk("p8_drained", 64'(p_out_valid), 64'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ext_unit_pipe.md
Name: ext_unit_pipe

Overview:
- Parametrised, registered successor of the 16->32 sign extender for the mips32 datapath.
- Extends an IN_W-bit operand to OUT_W bits in one of four modes: sign, zero, upper/LUI placement, or sub-word sign extension for lb/lh.
- The result is registered behind a valid/ready handshake with a 2-entry skid buffer, so the decode->execute path is cut without losing throughput.
- A pipeline tag travels alongside each operand; a flush input drops in-flight entries.

Parameters:
- IN_W, 16, input operand width.
- OUT_W, 32, output width; elaboration error if OUT_W < IN_W.
- SUB_W, 8, source width for SUBWORD mode; elaboration error if SUB_W > IN_W or SUB_W < 1.
- TAG_W, 5, width of the passthrough tag (e.g. destination register number).

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous; discards all held entries.
- in_valid  input  1  input operand valid.
- in_ready  output  1  unit can accept an operand this cycle.
- in_data  input  IN_W  operand to extend.
- in_mode  input  2  00 SIGN, 01 ZERO, 10 UPPER, 11 SUBWORD.
- in_tag  input  TAG_W  opaque tag, returned unchanged.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  OUT_W  extended result, registered.
- out_tag  output  TAG_W  tag of out_data.

Behaviour:
- Arithmetic, computed combinationally on the input side and registered on accept:
  - SIGN: in_data[IN_W-1] replicated into bits OUT_W-1..IN_W.
  - ZERO: upper OUT_W-IN_W bits = 0.
  - UPPER: in_data placed at bits OUT_W-1..OUT_W-IN_W, lower bits = 0. With defaults this is LUI.
  - SUBWORD: in_data[SUB_W-1:0] sign-extended to OUT_W; in_data bits above SUB_W-1 are ignored.
  - If OUT_W == IN_W, every mode returns in_data unchanged, except SUBWORD.
- Storage is a main register (M), which drives out_*, plus a skid register (S); each has a valid bit.
- Handshake rules:
  - in_ready = !S.valid, taken directly from a flop, with no combinational path from out_ready.
  - Accept = in_valid & in_ready. Deliver = out_valid & out_ready.
  - out_valid = M.valid.
- Per-cycle update, applied in priority order:
  - flush: M.valid = S.valid = 0. Any same-cycle accept is dropped. out_data and out_tag hold their old values.
  - Deliver and S.valid: S moves to M and S empties. A same-cycle accept is impossible because in_ready = 0.
  - Deliver and no S: M takes the accepted entry if there is an accept; otherwise M.valid = 0.
  - No deliver and M empty: M takes the accepted entry.
  - No deliver and M full: S takes the accepted entry. in_ready drops the next cycle.
- Latency: accept at edge N gives out_valid at edge N, i.e. visible in cycle N+1. Throughput is 1 per cycle when out_ready is held high.
- Ordering: strict FIFO. No reordering, no duplication, no loss except under flush.
- Data registers are loaded only when their valid bit is set by an accept or transfer. out_data must not change while out_valid & !out_ready (stable under backpressure).
- Reset values:
  - out_valid = 0, out_data = 0, out_tag = 0.
  - S.valid = 0, so in_ready = 1.
  - All internal data registers = 0.
- Reset mid-operation clears held entries immediately (asynchronously). The first accept is possible on the first edge after reset deasserts.
- Boundaries:
  - Full means M and S both valid and in_ready = 0. It is reached only by accepting while out_ready = 0 with M full.
  - Empty means out_valid = 0. out_ready is ignored while out_valid = 0.
  - in_mode, in_data and in_tag are ignored when there is no accept.

Decomposition:
- Shared package mips32_pkg gets:
  - the mode encodings EXT_SIGN = 2'b00, EXT_ZERO = 2'b01, EXT_UPPER = 2'b10, EXT_SUBWORD = 2'b11;
  - a function for the width check.
- One natural sub-module, ext_core: purely combinational mode/width extension, parametrised IN_W/OUT_W/SUB_W. It is reused by the load-alignment unit.
- ext_unit_pipe instantiates ext_core plus the M/S skid control.

Test Plan:
- Reset, then SIGN with in_data = 16'h8001, tag 3, out_ready = 1 -> next cycle out_valid = 1, out_data = 32'hFFFF8001, out_tag = 3. in_ready is 1 throughout.
- Back-to-back stream with out_ready = 1, modes SIGN 16'h7FFF, ZERO 16'h8001, UPPER 16'h1234, SUBWORD 16'h0080 -> outputs in order 32'h00007FFF, 32'h00008001, 32'h12340000, 32'hFFFFFF80, one per cycle.
- Backpressure: out_ready = 0 while pushing 3 operands -> only 2 accepted, in_ready = 0 after the second, out_data stable. Raise out_ready -> both delivered in order, then in_ready returns to 1 and the third is accepted.
- Flush with M and S full plus a simultaneous in_valid -> out_valid = 0 next cycle, in_ready = 1, and the flushed or dropped operands never appear.
- Assert reset asynchronously mid-stream (between edges) -> out_valid, out_data and out_tag go to 0 immediately. After deassertion, a new SIGN 16'hFFFF gives 32'hFFFFFFFF.
- Parameter sweep IN_W = 8, OUT_W = 16, SUB_W = 4 -> SUBWORD 8'h08 gives 16'hFFF8; UPPER 8'hAB gives 16'hAB00.
